// File: rtl/aes_batch_scheduler.sv
// aes_batch_scheduler: shares one N-lane AES engine between M requesters.
// Jobs are accepted round-robin into lane slots. A batch is issued when all
// lanes are full, or after FLUSH_CYCLES idle cycles with a partial batch.
// Results are returned in lane order, each tagged with its requester ID.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_FILL  | accepting jobs into lanes, one per cycle, round-robin
// S_ISSUE | one-cycle engine start pulse
// S_WAIT  | engine running, lane buses held; waiting for eng_done
// S_DRAIN | presenting results lane by lane on rsp_*
module aes_batch_scheduler #(
    parameter int N            = 4,
    parameter int M            = 2,
    parameter int ID_W         = 1,
    parameter int FLUSH_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [M-1:0]        req_valid,
    output logic [M-1:0]        req_ready,
    input  logic [128*M-1:0]    req_pt,
    input  logic [128*M-1:0]    req_key,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [127:0]        rsp_ct,
    output logic [ID_W-1:0]     rsp_id,
    output logic                eng_start,
    output logic [128*N-1:0]    eng_plain_text,
    output logic [128*N-1:0]    eng_cipher_key,
    input  logic                eng_done,
    input  logic [128*N-1:0]    eng_cipher_text,
    output logic                busy
);

    localparam int CNT_W  = $clog2(N + 1);
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int IDLE_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_FILL,
        S_ISSUE,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [IDX_W-1:0]  drain_q, drain_d;

    logic [127:0]      lane_pt_q  [N];
    logic [127:0]      lane_key_q [N];
    logic [ID_W-1:0]   lane_id_q  [N];
    logic [127:0]      result_q   [N];

    logic              grant_found;
    logic [ID_W-1:0]   grant_id;
    logic              accept;
    logic              flush_hit;
    logic              drain_last;
    logic              lane_wr;
    logic              res_wr;
    logic              batch_clr;

    // Requester index base+off wrapped into 0..M-1 (off never exceeds M).
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= M) s = s - M;
        return ID_W'(s);
    endfunction

    // Round-robin search for the first valid requester starting at rr_ptr.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = rr_ptr_q;
        for (int j = 0; j < M; j++) begin
            if (!grant_found && req_valid[wrap_add(rr_ptr_q, j)]) begin
                grant_found = 1'b1;
                grant_id    = wrap_add(rr_ptr_q, j);
            end
        end
    end

    assign drain_last = (CNT_W'(drain_q) == (count_q - CNT_W'(1)));

    // Next-state, control strobes and handshake outputs.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rr_ptr_d  = rr_ptr_q;
        idle_d    = idle_q;
        drain_d   = drain_q;
        lane_wr   = 1'b0;
        res_wr    = 1'b0;
        batch_clr = 1'b0;
        req_ready = '0;
        eng_start = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        flush_hit = 1'b0;
        unique case (state_q)
            S_FILL: begin
                if (grant_found && (count_q < CNT_W'(N)) && !rst) begin
                    req_ready[grant_id] = 1'b1;
                end
                accept = |(req_valid & req_ready);
                flush_hit = (FLUSH_CYCLES > 0) && (count_q != '0) && !accept &&
                            (idle_q == IDLE_W'(FLUSH_CYCLES - 1));
                if (accept) begin
                    lane_wr  = 1'b1;
                    count_d  = count_q + CNT_W'(1);
                    rr_ptr_d = wrap_add(grant_id, 1);
                    idle_d   = '0;
                    if (count_q == CNT_W'(N - 1)) state_d = S_ISSUE;
                end else begin
                    if ((count_q != '0) && (idle_q < IDLE_W'(FLUSH_CYCLES))) begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                    if (flush_hit) state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                eng_start = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done) begin
                    res_wr  = 1'b1;
                    drain_d = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    if (drain_last) begin
                        state_d   = S_FILL;
                        count_d   = '0;
                        idle_d    = '0;
                        drain_d   = '0;
                        batch_clr = 1'b1;
                    end else begin
                        drain_d = drain_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    // FSM and control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FILL;
            count_q  <= '0;
            rr_ptr_q <= '0;
            idle_q   <= '0;
            drain_q  <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rr_ptr_q <= rr_ptr_d;
            idle_q   <= idle_d;
            drain_q  <= drain_d;
        end
    end

    // Lane and result storage; lanes are cleared after each batch so
    // unfilled lanes of a partial batch present zero to the engine.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                lane_pt_q[k]  <= '0;
                lane_key_q[k] <= '0;
                lane_id_q[k]  <= '0;
                result_q[k]   <= '0;
            end
        end else begin
            if (batch_clr) begin
                for (int k = 0; k < N; k++) begin
                    lane_pt_q[k]  <= '0;
                    lane_key_q[k] <= '0;
                    lane_id_q[k]  <= '0;
                end
            end
            if (lane_wr) begin
                lane_pt_q[count_q[IDX_W-1:0]]  <= req_pt[128*int'(grant_id) +: 128];
                lane_key_q[count_q[IDX_W-1:0]] <= req_key[128*int'(grant_id) +: 128];
                lane_id_q[count_q[IDX_W-1:0]]  <= grant_id;
            end
            if (res_wr) begin
                for (int k = 0; k < N; k++) begin
                    result_q[k] <= eng_cipher_text[128*k +: 128];
                end
            end
        end
    end

    // Flatten lane registers onto the engine buses.
    always_comb begin
        eng_plain_text = '0;
        eng_cipher_key = '0;
        for (int k = 0; k < N; k++) begin
            eng_plain_text[128*k +: 128] = lane_pt_q[k];
            eng_cipher_key[128*k +: 128] = lane_key_q[k];
        end
    end

    assign rsp_ct = result_q[drain_q];
    assign rsp_id = lane_id_q[drain_q];
    assign busy   = (state_q != S_FILL);

endmodule

// File: doc/aes_batch_scheduler.md
Name: aes_batch_scheduler

Overview:
- Shares one N-lane AES encryption engine between M independent requesters.
- Accepts single 128-bit plaintext/key jobs per requester over valid/ready and packs them into lane slots using round-robin arbitration.
- Starts the engine once per batch, waits for completion, then returns each ciphertext tagged with its requester ID.
- Sits between client ports and the AES top's start/done/plain_text/cipher_key/cipher_text interface.

Parameters:
- N, 4, number of engine lanes (batch size).
- M, 2, number of requesters.
- ID_W, 1, width of requester ID; must satisfy 2**ID_W >= M.
- FLUSH_CYCLES, 16, idle cycles after which a partial batch is issued; 0 disables flush (issue only when full).

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- rst, input, 1, synchronous active-high reset.
- req_valid, input, M, per-requester job valid.
- req_ready, output, M, per-requester job accept (at most one bit high per cycle).
- req_pt, input, 128*M, plaintext; requester i at [128*i +: 128].
- req_key, input, 128*M, cipher key; requester i at [128*i +: 128].
- rsp_valid, output, 1, result valid.
- rsp_ready, input, 1, result accept.
- rsp_ct, output, 128, ciphertext.
- rsp_id, output, ID_W, requester that submitted this job.
- eng_start, output, 1, one-cycle engine start pulse.
- eng_plain_text, output, 128*N, lane plaintexts; lane k at [128*k +: 128].
- eng_cipher_key, output, 128*N, lane keys.
- eng_done, input, 1, engine completion.
- eng_cipher_text, input, 128*N, lane ciphertexts.
- busy, output, 1, high in ISSUE, WAIT and DRAIN.

Behaviour:
- Single clock domain, synchronous active-high rst.
- Reset values:
  - state = FILL; count = 0; rr_ptr = 0; idle_cnt = 0; drain_idx = 0.
  - eng_start = 0, rsp_valid = 0, busy = 0, req_ready = 0.
  - Lane registers and eng_* data buses = 0.
- Reset asserted in any state abandons the batch; outputs hold reset values from the next edge.
- The engine's active-low reset must be driven from ~rst at integration.
- FILL:
  - grant = first i with req_valid[i] = 1, searching rr_ptr, rr_ptr+1, ... mod M.
  - req_ready[grant] = 1 only if count < N; all other bits 0; all bits 0 outside FILL.
  - On req_valid[g] & req_ready[g]:
    - store pt, key and ID g into lane[count];
    - count += 1;
    - rr_ptr = (g+1) mod M;
    - idle_cnt = 0.
  - If no accept and count > 0: idle_cnt += 1, saturating at FLUSH_CYCLES.
- FILL exits to ISSUE at the edge where either:
  - count reaches N, or
  - FLUSH_CYCLES > 0, count > 0 and idle_cnt == FLUSH_CYCLES-1 with no accept that cycle.
  - Partial issue therefore occurs exactly FLUSH_CYCLES cycles after the last accept.
- ISSUE (one cycle):
  - eng_start = 1.
  - Lanes >= count drive zero pt/key.
  - Next state WAIT.
- WAIT:
  - eng_plain_text and eng_cipher_key held stable.
  - On the first cycle with eng_done = 1: latch eng_cipher_text into result registers; drain_idx = 0; go to DRAIN.
- DRAIN:
  - rsp_valid = 1; rsp_ct = result[drain_idx]; rsp_id = lane_id[drain_idx].
  - On rsp_ready: drain_idx += 1.
  - At drain_idx == count-1 with rsp_ready: rsp_valid drops the next cycle; count = 0, idle_cnt = 0; go to FILL.
  - rsp_ct and rsp_id are stable while rsp_valid & !rsp_ready.
  - Unused lanes are never presented.
- eng_done is ignored outside WAIT.
- No new request is accepted during ISSUE, WAIT or DRAIN.
- Responses return in lane order, which equals acceptance order.
- Latency: last accept (full batch) -> eng_start next cycle -> first rsp_valid one cycle after eng_done.
- Throughput: one accept per cycle in FILL.

Test Plan:
- Requester 0 submits 4 jobs, each pt=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f, with real AES engine:
  - single eng_start one cycle after 4th accept;
  - 4 responses, rsp_ct=69c4e0d86a7b0430d8cdb78070b4c55a, rsp_id=0.
- Both requesters hold req_valid high with distinct pts:
  - grants alternate 0,1,0,1;
  - rsp_id sequence 0,1,0,1, each ciphertext matching its pt.
- One job from requester 1, then idle:
  - eng_start exactly 16 cycles after accept;
  - lanes 1..3 zero;
  - exactly one response, rsp_id=1.
- rsp_ready held low 10 cycles in DRAIN:
  - rsp_valid stays 1 with rsp_ct/rsp_id unchanged;
  - req_ready=0 throughout;
  - results resume in order on release.
- rst pulsed for 1 cycle in WAIT, then eng_done arrives 5 cycles later:
  - all outputs at reset values;
  - no rsp_valid;
  - next job accepted into lane 0.
- eng_done forced high during FILL with 2 jobs pending:
  - no state change;
  - batch issues normally on flush.
